// File: rtl/fp_stream_accum_if.sv
// Handshake bundle for fp_stream_accum: element input channel and frame-result output channel.
interface fp_stream_accum_if #(
  parameter int BIT_W = 32,
  parameter int LEN_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [BIT_W-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [BIT_W-1:0] out_data;
  logic [LEN_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/fp_stream_accum.sv
// Streaming float reduction: folds a valid/ready frame into one sum through a single fadd.
// Optional FACC_ZERO_SKIP_EN: zero-exponent elements bypass the adder but still count.
module fp_stream_accum #(
  parameter int BIT_W = 32,
  parameter int EXP_W = 8,
  parameter int M_W   = 23,
  parameter int LEN_W = 8
) (
  input logic               clk,
  input logic               rst,
  fp_stream_accum_if.slave  s
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] SHIFT_LIM = EXP_W'(M_W);

  // Same-sign magnitude add with truncation; hidden bit is always assumed set.
  function automatic logic [BIT_W-1:0] fadd(input logic [BIT_W-1:0] a, input logic [BIT_W-1:0] b);
    logic             a_big;
    logic             sign_big;
    logic [EXP_W-1:0] e_big, e_small, diff, e_res;
    logic [M_W-1:0]   f_big, f_small, m_res;
    logic [M_W:0]     m_small;
    logic [M_W+1:0]   sum;
    if (a[BIT_W-2 -: EXP_W] == EXP_MAX || b[BIT_W-2 -: EXP_W] == EXP_MAX)
      return '0;
    a_big    = (a[BIT_W-2:0] >= b[BIT_W-2:0]);
    sign_big = a_big ? a[BIT_W-1] : b[BIT_W-1];
    if (a[BIT_W-1] != b[BIT_W-1])
      return {sign_big, {(BIT_W-1){1'b0}}};
    e_big   = a_big ? a[BIT_W-2 -: EXP_W] : b[BIT_W-2 -: EXP_W];
    e_small = a_big ? b[BIT_W-2 -: EXP_W] : a[BIT_W-2 -: EXP_W];
    f_big   = a_big ? a[M_W-1:0] : b[M_W-1:0];
    f_small = a_big ? b[M_W-1:0] : a[M_W-1:0];
    diff    = e_big - e_small;
    m_small = (diff > SHIFT_LIM) ? '0 : ({1'b1, f_small} >> diff);
    sum     = {2'b01, f_big} + {1'b0, m_small};
    if (sum[M_W+1]) begin
      e_res = e_big + 1'b1;
      m_res = sum[M_W:1];
    end else begin
      e_res = e_big;
      m_res = sum[M_W-1:0];
    end
    return {sign_big, e_res, m_res};
  endfunction

  state_t           state;
  logic [BIT_W-1:0] acc;
  logic [BIT_W-1:0] acc_nxt;
  logic [LEN_W-1:0] cnt;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             accept;

`ifdef FACC_ZERO_SKIP_EN
  logic has_data;
`endif

  assign accept = s.in_valid && in_ready_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    acc_nxt = fadd(acc, s.in_data);
    if (state == IDLE)
      acc_nxt = s.in_data;
`ifdef FACC_ZERO_SKIP_EN
    // Until a non-zero element lands, the next one loads directly instead of adding.
    if (!has_data)
      acc_nxt = s.in_data;
    if (s.in_data[BIT_W-2 -: EXP_W] == '0)
      acc_nxt = acc;
`endif
  end

  // NOTE: state is updated only with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (accept) begin
            acc <= acc_nxt;
            cnt <= (state == IDLE) ? LEN_W'(1) : cnt + 1'b1;
            if (s.in_last) begin
              state       <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state <= ACC;
            end
          end
        end
        DONE: begin
          if (s.out_ready) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FACC_ZERO_SKIP_EN
  always_ff @(posedge clk) begin
    if (rst)
      has_data <= 1'b0;
    else if (state == DONE && s.out_ready)
      has_data <= 1'b0;
    else if (accept && s.in_data[BIT_W-2 -: EXP_W] != '0)
      has_data <= 1'b1;
  end
`endif

  assign s.in_ready  = in_ready_q;
  assign s.out_valid = out_valid_q;
  assign s.out_data  = acc;
  assign s.out_count = cnt;

endmodule

// File: tb/tb_fp_stream_accum.sv
// Directed self-checking bench for fp_stream_accum with hand-computed float sums.
module tb_fp_stream_accum;

  localparam logic [31:0] F_0 = 32'h0000_0000;
  localparam logic [31:0] F_1 = 32'h3F80_0000;
  localparam logic [31:0] F_2 = 32'h4000_0000;
  localparam logic [31:0] F_3 = 32'h4040_0000;
  localparam logic [31:0] F_6 = 32'h40C0_0000;
  localparam logic [31:0] F_257 = 32'h4380_8000;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fp_stream_accum_if #(.BIT_W(32), .LEN_W(8)) bus ();

  fp_stream_accum #(.BIT_W(32), .EXP_W(8), .M_W(23), .LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] data, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_last  = last;
    for (int i = 0; i < 20 && !bus.in_ready; i++) tick();
    if (!bus.in_ready) check("send_ready_timeout", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_data"}, bus.out_data, 32'd0);
    check({tag, "_out_count"}, 32'(bus.out_count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // 1.0 + 2.0, result consumed immediately
    send(F_1, 1'b0);
    check("f1_valid_early", 32'(bus.out_valid), 32'd0);
    send(F_2, 1'b1);
    check("f1_valid", 32'(bus.out_valid), 32'd1);
    check("f1_in_ready", 32'(bus.in_ready), 32'd0);
    check("f1_data", bus.out_data, F_3);
    check("f1_count", 32'(bus.out_count), 32'd2);
    tick();
    check("f1_valid_drop", 32'(bus.out_valid), 32'd0);
    check("f1_ready_back", 32'(bus.in_ready), 32'd1);

    // 3.0 + 3.0 carries into the exponent; hold the result with back-pressure
    bus.out_ready = 1'b0;
    send(F_3, 1'b0);
    send(F_3, 1'b1);
    check("f2_data", bus.out_data, F_6);
    check("f2_count", 32'(bus.out_count), 32'd2);
    bus.in_valid = 1'b1;
    bus.in_data  = F_1;
    bus.in_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("f2_hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("f2_hold_valid", 32'(bus.out_valid), 32'd1);
      check("f2_hold_data", bus.out_data, F_6);
      check("f2_hold_count", 32'(bus.out_count), 32'd2);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("f2_valid_drop", 32'(bus.out_valid), 32'd0);
    check("f2_cleared_data", bus.out_data, 32'd0);

    // Single-element frame; also proves nothing was swallowed during the hold
    send(F_3, 1'b1);
    check("f3_valid", 32'(bus.out_valid), 32'd1);
    check("f3_data", bus.out_data, F_3);
    check("f3_count", 32'(bus.out_count), 32'd1);
    tick();

    // Reset mid-frame, colliding with the would-be last element
    send(F_1, 1'b0);
    send(F_1, 1'b0);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = F_1;
    bus.in_last  = 1'b1;
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check_reset_outputs("midrst");
    send(F_2, 1'b1);
    check("f4_data", bus.out_data, F_2);
    check("f4_count", 32'(bus.out_count), 32'd1);
    tick();

    // Zero leading element: skipped, or added as fadd(0, 2.0) which truncates to 2.0
    send(F_0, 1'b0);
    send(F_2, 1'b1);
    check("f5_data", bus.out_data, F_2);
    check("f5_count", 32'(bus.out_count), 32'd2);
    tick();

    // 257 ones with random gaps: count wraps to 1, sum is exactly 257.0
    for (int i = 0; i < 257; i++) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      send(F_1, (i == 256));
    end
    check("f6_valid", 32'(bus.out_valid), 32'd1);
    check("f6_data", bus.out_data, F_257);
    check("f6_count", 32'(bus.out_count), 32'd1);
    tick();
    check("f6_valid_drop", 32'(bus.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
